// File: rtl/bidir_bus_ctrl_if.sv
// Request/response and iobuf-side signals of the half-duplex bus sequencer.
// Latency: none, this file only bundles wires.
// Backpressure: req_valid/req_ready handshake; the iobuf side has no flow control.
//
// Signals:
//   req_valid/req_ready/req_we/req_wdata  request port (one op at a time)
//   rsp_valid/rsp_rdata                   read response (pulse / held data)
//   bus_cmd_wr/bus_cmd_rd                 one-cycle strobes to the device
//   buf_en/buf_i/buf_o                    iobuf tri-state control, drive and bus value
// Modports: slave = the sequencer, master = the requester plus iobuf side.
interface bidir_bus_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;
  logic             bus_cmd_wr;
  logic             bus_cmd_rd;
  logic             buf_en;
  logic [WIDTH-1:0] buf_i;
  logic [WIDTH-1:0] buf_o;

  modport slave (
    input  req_valid, req_we, req_wdata, buf_o,
    output req_ready, rsp_valid, rsp_rdata, bus_cmd_wr, bus_cmd_rd, buf_en, buf_i
  );

  modport master (
    output req_valid, req_we, req_wdata, buf_o,
    input  req_ready, rsp_valid, rsp_rdata, bus_cmd_wr, bus_cmd_rd, buf_en, buf_i
  );
endinterface

// File: rtl/bidir_bus_ctrl.sv
// Sequencer for a shared half-duplex bus feeding an iobuf; inserts turnaround on direction change.
// Latency: write strobe 1 cycle after accept, read response 2+RD_LAT cycles (+TURN on a direction change).
// Backpressure: req_ready high only in IDLE; one op outstanding, nothing queued.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; aborts any op, releases the bus next cycle
//   bus   bidir_bus_ctrl_if.slave: request port, read response, device strobes, iobuf control
// All outputs are registered except req_ready, which decodes the state register only.
module bidir_bus_ctrl #(
  parameter int WIDTH  = 16,
  parameter int RD_LAT = 2,   // cycles from bus_cmd_rd to valid data on buf_o, >= 1
  parameter int TURN   = 1    // released idle cycles on a direction change, 0 = none
) (
  input  logic            clk,
  input  logic            rst,
  bidir_bus_ctrl_if.slave bus
);

  localparam int MAX_CNT = (RD_LAT > TURN) ? RD_LAT : TURN;
  localparam int CW      = $clog2(MAX_CNT + 1);
  // Counters count down to zero, so they are loaded with (cycles - 1).
  localparam logic [CW-1:0] TURN_LD = CW'((TURN > 0) ? TURN - 1 : 0);
  // RD_WAIT spans RD_LAT-1 cycles; it is skipped entirely when RD_LAT == 1.
  localparam logic [CW-1:0] WAIT_LD = CW'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN,
    ST_WRITE,
    ST_RD_CMD,
    ST_RD_WAIT,
    ST_RD_CAP
  } state_t;

  typedef enum logic {
    DIR_RELEASED = 1'b0,
    DIR_DRIVEN   = 1'b1
  } dir_t;

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  dir_t             want_dir;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             buf_en_q, buf_en_d;
  logic [WIDTH-1:0] buf_i_q, buf_i_d;
  logic             cmd_wr_q, cmd_wr_d;
  logic             cmd_rd_q, cmd_rd_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  assign want_dir = bus.req_we ? DIR_DRIVEN : DIR_RELEASED;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_RELEASED;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      buf_en_q    <= 1'b1;
      buf_i_q     <= '0;
      cmd_wr_q    <= 1'b0;
      cmd_rd_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      buf_en_q    <= buf_en_d;
      buf_i_q     <= buf_i_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_rd_q    <= cmd_rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    dir_d       = dir_q;
    buf_en_d    = buf_en_q;
    buf_i_d     = buf_i_q;
    cmd_wr_d    = 1'b0;
    cmd_rd_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    // Next state.
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          wdata_d = bus.req_wdata;
          if ((TURN > 0) && (want_dir != dir_q)) begin
            state_d = ST_TURN;
            cnt_d   = TURN_LD;
          end else begin
            state_d = bus.req_we ? ST_WRITE : ST_RD_CMD;
          end
        end
      end
      ST_TURN: begin
        if (cnt_q == '0) begin
          state_d = we_q ? ST_WRITE : ST_RD_CMD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_RD_CMD: begin
        if (RD_LAT > 1) begin
          state_d = ST_RD_WAIT;
          cnt_d   = WAIT_LD;
        end else begin
          state_d = ST_RD_CAP;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RD_CAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RD_CAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered outputs are decoded from the state being entered so they
    // line up with that state's cycle. In IDLE buf_en keeps its last value:
    // a write leaves the bus driven, a read leaves it released.
    case (state_d)
      ST_WRITE: begin
        buf_en_d = 1'b0;
        buf_i_d  = wdata_d;   // req_wdata on a direct accept, latched copy after TURN
        cmd_wr_d = 1'b1;
        dir_d    = DIR_DRIVEN;
      end
      ST_TURN: begin
        buf_en_d = 1'b1;
        dir_d    = DIR_RELEASED;
      end
      ST_RD_CMD: begin
        buf_en_d = 1'b1;
        cmd_rd_d = 1'b1;
        dir_d    = DIR_RELEASED;  // also covers TURN == 0, where no TURN state is entered
      end
      ST_RD_WAIT, ST_RD_CAP: begin
        buf_en_d = 1'b1;
      end
      default: begin
      end
    endcase

    // The edge ending RD_CAP is RD_LAT cycles after the RD_CMD cycle.
    if (state_q == ST_RD_CAP) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = bus.buf_o;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.buf_en     = buf_en_q;
  assign bus.buf_i      = buf_i_q;
  assign bus.bus_cmd_wr = cmd_wr_q;
  assign bus.bus_cmd_rd = cmd_rd_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;

endmodule
